// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - fetch-side push and consumer-side pop handshake bundle for decode_queue
interface decode_queue_if #(
    parameter int INSTR_SIZE = 32,
    parameter int PC_SIZE    = 32,
    parameter int REG_IDX    = 5,
    parameter int DEPTH      = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [INSTR_SIZE-1:0]        in_instr;
    logic [PC_SIZE-1:0]           in_pc;
    logic                         out_valid;
    logic                         out_ready;
    logic [PC_SIZE-1:0]           out_pc;
    logic [REG_IDX-1:0]           out_rs1;
    logic [REG_IDX-1:0]           out_rs2;
    logic [REG_IDX-1:0]           out_rd;
    logic [31:0]                  out_imm;
    logic [5:0]                   out_type;
    logic                         out_illegal;
    logic [PC_SIZE-1:0]           out_target;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_imm, out_type, out_illegal, out_target, count
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_imm, out_type, out_illegal, out_target, count
    );
endinterface

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - RV32IM decode-on-entry FIFO between fetch and rename/issue
module decode_queue #(
    parameter int INSTR_SIZE = 32,
    parameter int PC_SIZE    = 32,
    parameter int REG_IDX    = 5,
    parameter int DEPTH      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    decode_queue_if.slave  q
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [5:0] T_R = 6'b000001;
    localparam logic [5:0] T_I = 6'b000010;
    localparam logic [5:0] T_S = 6'b000100;
    localparam logic [5:0] T_B = 6'b001000;
    localparam logic [5:0] T_U = 6'b010000;
    localparam logic [5:0] T_J = 6'b100000;

    typedef struct packed {
        logic               ill;
        logic [5:0]         typ;
        logic [PC_SIZE-1:0] tgt;
        logic [31:0]        imm;
        logic [REG_IDX-1:0] rd;
        logic [REG_IDX-1:0] rs2;
        logic [REG_IDX-1:0] rs1;
        logic [PC_SIZE-1:0] pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          dec;
    entry_t          head;
    logic            push, pop;
    logic [31:0]     ins;
    logic            unused_funct3;

    assign ins           = q.in_instr[31:0];
    assign unused_funct3 = ^ins[14:12];

    always_comb begin
        dec     = '0;
        dec.pc  = q.in_pc;
        case (ins[6:0])
            7'b0110011: begin
                if (ins[31:25] == 7'h00 || ins[31:25] == 7'h20 || ins[31:25] == 7'h01) begin
                    dec.typ = T_R;
                    dec.rd  = REG_IDX'(ins[11:7]);
                    dec.rs1 = REG_IDX'(ins[19:15]);
                    dec.rs2 = REG_IDX'(ins[24:20]);
                end else begin
                    dec.ill = 1'b1;
                end
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec.typ = T_I;
                dec.rd  = REG_IDX'(ins[11:7]);
                dec.rs1 = REG_IDX'(ins[19:15]);
                dec.imm = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                dec.typ = T_S;
                dec.rs1 = REG_IDX'(ins[19:15]);
                dec.rs2 = REG_IDX'(ins[24:20]);
                dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                dec.typ = T_B;
                dec.rs1 = REG_IDX'(ins[19:15]);
                dec.rs2 = REG_IDX'(ins[24:20]);
                dec.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b1101111: begin
                dec.typ = T_J;
                dec.rd  = REG_IDX'(ins[11:7]);
                dec.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b0010111, 7'b0110111: begin
                dec.typ = T_U;
                dec.rd  = REG_IDX'(ins[11:7]);
                dec.imm = {ins[31:12], 12'b0};
            end
            default: dec.ill = 1'b1;
        endcase
        // Only control-transfer types carry a PC-relative target.
        if (dec.typ == T_B || dec.typ == T_J) begin
            dec.tgt = q.in_pc + dec.imm[PC_SIZE-1:0];
        end
    end

    assign q.in_ready  = (count_q != FULL);
    assign q.out_valid = (count_q != '0);
    assign push        = q.in_valid & q.in_ready & ~flush;
    assign pop         = q.out_valid & q.out_ready & ~flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Masked so the consumer never sees stale data while the queue is empty.
    assign head          = q.out_valid ? mem_q[rd_ptr_q] : '0;
    assign q.out_pc      = head.pc;
    assign q.out_rs1     = head.rs1;
    assign q.out_rs2     = head.rs2;
    assign q.out_rd      = head.rd;
    assign q.out_imm     = head.imm;
    assign q.out_type    = head.typ;
    assign q.out_illegal = head.ill;
    assign q.out_target  = head.tgt;
    assign q.count       = count_q;
endmodule
